// File: rtl/alu_issue_pkg.sv
// Shared opcodes, flag positions and FSM encoding for the ALU issue controller.
// Consumers import with: import alu_issue_pkg::*;
package alu_issue_pkg;

    localparam logic [2:0] OP_SLA = 3'd0;
    localparam logic [2:0] OP_SRA = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_SUB = 3'd3;
    localparam logic [2:0] OP_MUL = 3'd4;
    localparam logic [2:0] OP_AND = 3'd5;
    localparam logic [2:0] OP_OR  = 3'd6;
    localparam logic [2:0] OP_NOT = 3'd7;

    // Bit of the ALU flag vector that carries signed overflow.
    localparam int FLAG_OVF = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } state_t;

endpackage

// File: rtl/alu_issue_ctrl_regfile.sv
// Register file for the issue controller: async clear, one write port and
// three asynchronous read ports (two operand reads, one host read).
module alu_regfile
#(
    parameter int DATA_W = 32,
    parameter int AW     = 3
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     ra1,
    output logic [DATA_W-1:0] rd1,
    input  logic [AW-1:0]     ra2,
    output logic [DATA_W-1:0] rd2,
    input  logic [AW-1:0]     ra3,
    output logic [DATA_W-1:0] rd3
);

    logic [DATA_W-1:0] mem_q [2**AW];

    // Storage array: cleared on reset, single write per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2**AW; i++) begin
                mem_q[i] <= {DATA_W{1'b0}};
            end
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rd1 = mem_q[ra1];
    assign rd2 = mem_q[ra2];
    assign rd3 = mem_q[ra3];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/write-back sequencer wrapped around a combinational ALU.
// Optional feature: define ALU_ISSUE_STICKY_OVF_EN to enable the sticky overflow flag.
module alu_issue_ctrl
    import alu_issue_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int AW     = 3,
    parameter int FLAG_W = 3
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_load,
    input  logic [2:0]        in_op,
    input  logic [AW-1:0]     in_rd,
    input  logic [AW-1:0]     in_rs1,
    input  logic [AW-1:0]     in_rs2,
    input  logic [DATA_W-1:0] in_imm,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_op,
    input  logic [DATA_W-1:0] alu_c,
    input  logic [FLAG_W-1:0] alu_d,
    output logic              done,
    output logic [DATA_W-1:0] out_result,
    output logic [FLAG_W-1:0] out_flags,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data,
    input  logic              clr_sticky,
    output logic              sticky_ovf
);

    state_t              state_q, state_d;
    logic                load_q, load_d;
    logic [2:0]          op_q, op_d;
    logic [AW-1:0]       rd_q, rd_d;
    logic [AW-1:0]       rs1_q, rs1_d;
    logic [AW-1:0]       rs2_q, rs2_d;
    logic [DATA_W-1:0]   res_q, res_d;
    logic [FLAG_W-1:0]   flg_q, flg_d;
    logic [DATA_W-1:0]   alu_a_q, alu_a_d;
    logic [DATA_W-1:0]   alu_b_q, alu_b_d;
    logic [2:0]          alu_op_q, alu_op_d;
    logic [DATA_W-1:0]   out_result_q, out_result_d;
    logic [FLAG_W-1:0]   out_flags_q, out_flags_d;
    logic                done_q, done_d;
    logic                sticky_q, sticky_d;
    logic                rf_we_s;
    logic [DATA_W-1:0]   rs1_data_s, rs2_data_s;

    alu_regfile #(.DATA_W(DATA_W), .AW(AW)) u_rf (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (rf_we_s),
        .waddr (rd_q),
        .wdata (res_q),
        .ra1   (rs1_q),
        .rd1   (rs1_data_s),
        .ra2   (rs2_q),
        .rd2   (rs2_data_s),
        .ra3   (rd_addr),
        .rd3   (rd_data)
    );

    // Next-state, datapath capture and write-back control.
    always_comb begin
        state_d      = state_q;
        load_d       = load_q;
        op_d         = op_q;
        rd_d         = rd_q;
        rs1_d        = rs1_q;
        rs2_d        = rs2_q;
        res_d        = res_q;
        flg_d        = flg_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_op_d     = alu_op_q;
        out_result_d = out_result_q;
        out_flags_d  = out_flags_q;
        rf_we_s      = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    load_d  = in_load;
                    op_d    = in_op;
                    rd_d    = in_rd;
                    rs1_d   = in_rs1;
                    rs2_d   = in_rs2;
                    // Loads park the immediate in res so WB has a single source.
                    res_d   = in_imm;
                    state_d = in_load ? WB : READ;
                end else begin
                    state_d = IDLE;
                end
            end
            READ: begin
                alu_a_d  = rs1_data_s;
                alu_b_d  = rs2_data_s;
                alu_op_d = op_q;
                state_d  = EXEC;
            end
            EXEC: begin
                res_d   = alu_c;
                flg_d   = alu_d;
                state_d = WB;
            end
            WB: begin
                rf_we_s      = 1'b1;
                out_result_d = res_q;
                if (!load_q) begin
                    out_flags_d = flg_q;
                end else begin
                    out_flags_d = out_flags_q;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        done_d = (state_d == WB);
    end

`ifdef ALU_ISSUE_STICKY_OVF_EN
    // Sticky overflow: a set event in WB takes priority over a clear request.
    always_comb begin
        if ((state_q == WB) && !load_q && flg_q[FLAG_OVF]) begin
            sticky_d = 1'b1;
        end else if (clr_sticky) begin
            sticky_d = 1'b0;
        end else begin
            sticky_d = sticky_q;
        end
    end
`else
    logic unused_clr_sticky_s;
    assign unused_clr_sticky_s = clr_sticky;

    // Feature disabled: flag held at zero.
    always_comb begin
        sticky_d = 1'b0;
    end
`endif

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            load_q       <= 1'b0;
            op_q         <= 3'd0;
            rd_q         <= {AW{1'b0}};
            rs1_q        <= {AW{1'b0}};
            rs2_q        <= {AW{1'b0}};
            res_q        <= {DATA_W{1'b0}};
            flg_q        <= {FLAG_W{1'b0}};
            alu_a_q      <= {DATA_W{1'b0}};
            alu_b_q      <= {DATA_W{1'b0}};
            alu_op_q     <= 3'd0;
            out_result_q <= {DATA_W{1'b0}};
            out_flags_q  <= {FLAG_W{1'b0}};
            done_q       <= 1'b0;
            sticky_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            load_q       <= load_d;
            op_q         <= op_d;
            rd_q         <= rd_d;
            rs1_q        <= rs1_d;
            rs2_q        <= rs2_d;
            res_q        <= res_d;
            flg_q        <= flg_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_op_q     <= alu_op_d;
            out_result_q <= out_result_d;
            out_flags_q  <= out_flags_d;
            done_q       <= done_d;
            sticky_q     <= sticky_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_op     = alu_op_q;
    assign done       = done_q;
    assign out_result = out_result_q;
    assign out_flags  = out_flags_q;
    assign sticky_ovf = sticky_q;

endmodule
